// File: rtl/unified_mem_arbiter_pkg.sv
// Shared definitions for the unified memory arbiter.
//  - arb_state_e : arbiter FSM states (2-bit encoding)
//  - owner_e     : owner of the transaction currently on the memory port
//  - cnt_width() : width of a counter that must hold 0..max
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_BUSY_IF = 2'b01,
    ARB_BUSY_DM = 2'b10
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam int ADDR_W_DEF     = 16;
  localparam int DATA_W_DEF     = 16;
  localparam int STARVE_MAX_DEF = 4;

  // BUSY state that corresponds to a given owner.
  function automatic arb_state_e busy_state(owner_e owner);
    return (owner == OWN_DM) ? ARB_BUSY_DM : ARB_BUSY_IF;
  endfunction

  // Bits needed to count from 0 up to and including max.
  function automatic int cnt_width(int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the IF stage, the MEM stage, the arbiter and the memory.
//  IF side  : if_req, if_addr, if_flush -> ; <- if_ready, if_rdata
//  DM side  : dm_req, dm_we, dm_addr, dm_wdata -> ; <- dm_ready, dm_rdata
//  Memory   : <- mem_en, mem_we, mem_addr, mem_wdata ; mem_rdata, mem_valid ->
// Modports:
//  slave  : the arbiter (consumes requests and memory completions)
//  master : the environment (pipeline stages plus memory)
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_ready;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ready;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_ready, if_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_ready, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_valid
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_ready, if_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_ready, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_valid
  );

endinterface

// File: rtl/unified_mem_arbiter_starve_counter.sv
// Counts consecutive data grants taken while a fetch was waiting.
// Ports:
//  clk, rst_n : clock, synchronous active-low reset
//  inc        : data grant with an effective fetch pending (saturates)
//  clr        : fetch grant; clear has priority over inc
//  sat        : count has reached STARVE_MAX, fetch must win next
module starve_counter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CW = cnt_width(STARVE_MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  assign sat = (cnt_q == CW'(STARVE_MAX));

  // NOTE: combinational blocks assign every output a default first so no
  // path through the block can leave a value unassigned and infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported unified memory between instruction fetch (IF)
// and data access (DM). One transaction at a time; the grant is registered in
// IDLE, the memory port is driven from latched request fields, and the
// completion is steered back to the owner combinationally. Data wins unless
// fetch has been passed over STARVE_MAX times in a row. A fetch may be
// cancelled (if_flush) while pending or in flight; the memory access still
// runs to completion but its data is discarded.
// Ports:
//  clk   : clock, rising edge
//  rst_n : synchronous active-low reset
//  bus   : request/response/memory bundle (slave side)
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  unified_mem_arbiter_if.slave  bus
);

  arb_state_e        state_q, state_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cancel_q, cancel_d;

  logic              if_eff;
  logic              grant_if, grant_dm;
  logic              starve_sat;
  logic              if_ready, dm_ready;
  logic [DATA_W-1:0] if_rdata, dm_rdata;

  // A flushed fetch request is not a request at all.
  assign if_eff = bus.if_req && !bus.if_flush;

  starve_counter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (grant_dm && if_eff),
    .clr   (grant_if),
    .sat   (starve_sat)
  );

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cancel_d    = 1'b0;
    grant_if    = 1'b0;
    grant_dm    = 1'b0;
    if_ready    = 1'b0;
    if_rdata    = '0;
    dm_ready    = 1'b0;
    dm_rdata    = '0;

    unique case (state_q)
      ARB_IDLE: begin
        // mem_valid is ignored here: a stale completion has no owner.
        if (bus.dm_req && (!if_eff || !starve_sat)) begin
          grant_dm    = 1'b1;
          state_d     = busy_state(OWN_DM);
          mem_we_d    = bus.dm_we;
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
        end else if (if_eff) begin
          grant_if    = 1'b1;
          state_d     = busy_state(OWN_IF);
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = '0;
        end
      end

      ARB_BUSY_IF: begin
        if (bus.mem_valid) begin
          state_d = ARB_IDLE;
          // A flush in this very cycle also suppresses the response.
          if (!(cancel_q || bus.if_flush)) begin
            if_ready = 1'b1;
            if_rdata = bus.mem_rdata;
          end
        end else begin
          // Cancel is sticky only while the access is still outstanding.
          cancel_d = cancel_q || bus.if_flush;
        end
      end

      ARB_BUSY_DM: begin
        if (bus.mem_valid) begin
          state_d  = ARB_IDLE;
          dm_ready = 1'b1;
          dm_rdata = mem_we_q ? '0 : bus.mem_rdata;
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cancel_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cancel_q    <= cancel_d;
    end
  end

  assign bus.mem_en    = (state_q != ARB_IDLE);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  assign bus.if_ready  = if_ready;
  assign bus.if_rdata  = if_rdata;
  assign bus.dm_ready  = dm_ready;
  assign bus.dm_rdata  = dm_rdata;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter. A transaction-level model (one
// outstanding access, a wait countdown, a starve tally and a word array that
// doubles as the memory) predicts every output each cycle; directed scenarios
// add literal expectations on latency, data and grant order.
module tb_unified_mem_arbiter;

  localparam int SM = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  unified_mem_arbiter #(
    .ADDR_W     (16),
    .DATA_W     (16),
    .STARVE_MAX (SM)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [15:0] mem_model [0:255];

  // Model of the outstanding transaction.
  bit          m_busy, m_own_dm, m_we, m_cancel, m_clean;
  logic [15:0] m_addr, m_wdata;
  int          m_wait, m_starve;
  int          wait_n;
  bit          stale;

  // Outputs sampled in the last cycle.
  logic        s_if_ready, s_dm_ready, s_mem_en;
  logic [15:0] s_if_rdata, s_dm_rdata, s_mem_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  task automatic compare();
    bit          completing, e_if_ready, e_dm_ready;
    logic [15:0] word, e_if_rdata, e_dm_rdata;
    word       = mem_model[m_addr[7:0]];
    completing = m_busy && bus.mem_valid;
    e_if_ready = completing && !m_own_dm && !m_cancel && !bus.if_flush;
    e_dm_ready = completing && m_own_dm;
    e_if_rdata = e_if_ready ? word : 16'h0000;
    e_dm_rdata = (e_dm_ready && !m_we) ? word : 16'h0000;

    check("if_ready", bus.if_ready, e_if_ready);
    check("if_rdata", bus.if_rdata, e_if_rdata);
    check("dm_ready", bus.dm_ready, e_dm_ready);
    check("dm_rdata", bus.dm_rdata, e_dm_rdata);
    check("mem_en",   bus.mem_en,   m_busy);
    check("ready_exclusive", bus.if_ready & bus.dm_ready, 1'b0);
    if (m_busy) begin
      check("mem_we",    bus.mem_we,    m_we);
      check("mem_addr",  bus.mem_addr,  m_addr);
      check("mem_wdata", bus.mem_wdata, m_wdata);
    end else if (m_clean) begin
      check("mem_we_rst",    bus.mem_we,    1'b0);
      check("mem_addr_rst",  bus.mem_addr,  16'h0000);
      check("mem_wdata_rst", bus.mem_wdata, 16'h0000);
    end
    assert (!(m_busy && m_own_dm && rst_n && !bus.dm_req))
      else $error("dm_req dropped while a data access is in flight");

    s_if_ready = bus.if_ready;
    s_if_rdata = bus.if_rdata;
    s_dm_ready = bus.dm_ready;
    s_dm_rdata = bus.dm_rdata;
    s_mem_en   = bus.mem_en;
    s_mem_addr = bus.mem_addr;
  endtask

  task automatic update();
    bit if_eff;
    if (!rst_n) begin
      m_busy   = 1'b0;
      m_starve = 0;
      m_cancel = 1'b0;
      m_clean  = 1'b1;
    end else if (m_busy) begin
      if (!m_own_dm && bus.if_flush) m_cancel = 1'b1;
      if (bus.mem_valid) begin
        if (m_we) mem_model[m_addr[7:0]] = m_wdata;
        m_busy   = 1'b0;
        m_cancel = 1'b0;
      end else begin
        m_wait--;
      end
    end else begin
      if_eff = bus.if_req && !bus.if_flush;
      if (bus.dm_req && (!if_eff || m_starve < SM)) begin
        m_busy = 1'b1; m_own_dm = 1'b1; m_we = bus.dm_we;
        m_addr = bus.dm_addr; m_wdata = bus.dm_wdata;
        m_wait = wait_n; m_clean = 1'b0;
        if (if_eff) m_starve++;
      end else if (if_eff) begin
        m_busy = 1'b1; m_own_dm = 1'b0; m_we = 1'b0;
        m_addr = bus.if_addr; m_wdata = 16'h0000;
        m_wait = wait_n; m_clean = 1'b0;
        m_starve = 0;
      end
    end
  endtask

  // One clock cycle: memory responds, outputs compared mid-cycle, model steps at the edge.
  task automatic cycle();
    bus.mem_valid = (m_busy && m_wait == 0) || stale;
    bus.mem_rdata = bus.mem_valid ? mem_model[m_addr[7:0]] : 16'hDEAD;
    #2;
    compare();
    @(posedge clk);
    update();
    #1;
  endtask

  // Run until the selected ready is seen; cyc is its index counting the request cycle as 0.
  task automatic wait_ready(input bit dm, input int max, output int cyc);
    cyc = -1;
    for (int c = 0; c <= max; c++) begin
      cycle();
      if (dm ? s_dm_ready : s_if_ready) begin
        cyc = c;
        return;
      end
    end
    fail(dm ? "dm_ready_timeout" : "if_ready_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    bit got_if_ready;
    bit prev_en;
    int n_grants;
    bit grant_dm_log [10];
    bit exp_order [10];
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    for (int i = 0; i < 256; i++) mem_model[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
    mem_model[8'h10] = 16'h1234;
    mem_model[8'h30] = 16'hC0DE;

    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.mem_valid = 1'b0; bus.mem_rdata = '0;
    m_busy = 0; m_own_dm = 0; m_we = 0; m_cancel = 0; m_clean = 1;
    m_addr = '0; m_wdata = '0; m_wait = 0; m_starve = 0;
    wait_n = 0; stale = 0;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state.
    cycle();
    check("reset_mem_en", s_mem_en, 1'b0);

    // Single fetch, zero wait.
    bus.if_req = 1'b1; bus.if_addr = 16'h0010; wait_n = 0;
    cycle();
    check("fetch_c0_mem_en", s_mem_en, 1'b0);
    cycle();
    check("fetch_c1_mem_en",   s_mem_en,   1'b1);
    check("fetch_c1_mem_addr", s_mem_addr, 16'h0010);
    check("fetch_c1_ready",    s_if_ready, 1'b1);
    check("fetch_c1_rdata",    s_if_rdata, 16'h1234);
    bus.if_req = 1'b0;
    cycle();

    // Store then load, with a flush held during the load (no effect on data).
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 16'h0040; bus.dm_wdata = 16'hBEEF;
    wait_n = 2;
    wait_ready(1'b1, 10, c);
    check("store_latency", c, 3);
    check("store_rdata",   s_dm_rdata, 16'h0000);
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_wdata = '0;
    cycle();
    bus.dm_req = 1'b1; bus.if_flush = 1'b1; wait_n = 1;
    wait_ready(1'b1, 10, c);
    check("load_latency", c, 2);
    check("load_rdata",   s_dm_rdata, 16'hBEEF);
    bus.dm_req = 1'b0; bus.if_flush = 1'b0;
    cycle();

    // Contention: both held, zero wait.
    bus.if_req = 1'b1; bus.if_addr = 16'h0090;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 16'h0080;
    wait_n = 0; prev_en = 1'b0; n_grants = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (s_mem_en && !prev_en && n_grants < 10) begin
        grant_dm_log[n_grants] = (s_mem_addr == 16'h0080);
        n_grants++;
      end
      prev_en = s_mem_en;
    end
    check("contention_grants", n_grants, 10);
    for (int i = 0; i < 10; i++) check($sformatf("grant_order_%0d", i), grant_dm_log[i], exp_order[i]);
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    cycle();

    // Flush in flight: fetch 0x0020, wait 3, flush in cycle 2.
    bus.if_req = 1'b1; bus.if_addr = 16'h0020; wait_n = 3; got_if_ready = 1'b0;
    cycle();                               got_if_ready |= s_if_ready;
    cycle();                               got_if_ready |= s_if_ready;
    bus.if_flush = 1'b1;
    cycle();                               got_if_ready |= s_if_ready;
    check("flush_c2_mem_en", s_mem_en, 1'b1);
    bus.if_flush = 1'b0; bus.if_req = 1'b0;
    cycle();                               got_if_ready |= s_if_ready;
    check("flush_c3_mem_en", s_mem_en, 1'b1);
    cycle();                               got_if_ready |= s_if_ready;
    check("flush_c4_mem_en", s_mem_en, 1'b1);
    check("flush_no_ready", got_if_ready, 1'b0);
    bus.if_req = 1'b1; bus.if_addr = 16'h0030; wait_n = 0;
    cycle();
    check("flush_c5_mem_en", s_mem_en, 1'b0);
    cycle();
    check("refetch_ready", s_if_ready, 1'b1);
    check("refetch_rdata", s_if_rdata, 16'hC0DE);
    bus.if_req = 1'b0;
    cycle();

    // Flush coincident with completion.
    bus.if_req = 1'b1; bus.if_addr = 16'h0010; wait_n = 1;
    cycle();
    cycle();
    bus.if_flush = 1'b1;
    cycle();
    check("coinc_ready", s_if_ready, 1'b0);
    check("coinc_rdata", s_if_rdata, 16'h0000);
    bus.if_flush = 1'b0; bus.if_req = 1'b0;
    cycle();
    check("coinc_idle_mem_en", s_mem_en, 1'b0);

    // Flush in IDLE blocks the fetch grant.
    bus.if_req = 1'b1; bus.if_flush = 1'b1;
    cycle();
    bus.if_req = 1'b0; bus.if_flush = 1'b0;
    cycle();
    check("idle_flush_no_grant", s_mem_en, 1'b0);

    // Reset during a data access, then a stale mem_valid.
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 16'h0040; wait_n = 5;
    cycle();
    cycle();
    check("rst_busy_mem_en", s_mem_en, 1'b1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1; bus.dm_req = 1'b0;
    cycle();
    check("rst_mem_en",   s_mem_en,   1'b0);
    check("rst_mem_addr", s_mem_addr, 16'h0000);
    check("rst_dm_ready", s_dm_ready, 1'b0);
    stale = 1'b1;
    cycle();
    check("stale_dm_ready", s_dm_ready, 1'b0);
    check("stale_if_ready", s_if_ready, 1'b0);
    stale = 1'b0;
    cycle();
    check("stale_mem_en", s_mem_en, 1'b0);

    // Recovery fetch after reset.
    bus.if_req = 1'b1; bus.if_addr = 16'h0030; wait_n = 0;
    wait_ready(1'b0, 10, c);
    check("post_rst_latency", c, 1);
    check("post_rst_rdata",   s_if_rdata, 16'hC0DE);
    bus.if_req = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
